// File: rtl/mem_stage_hs.sv
// -----------------------------------------------------------------------------
// mem_stage_hs : pipeline memory stage with a request/ack data-memory handshake.
//
// Non-memory ops pass through in one cycle. Loads and stores issue one request
// and hold it until dmem_ack_i. Results are then presented downstream, and they
// are held in DONE for as long as stall_i stays high.
//
// Optional feature: define MEM_STALL_CNT_EN to build a saturating counter of
// stall_o cycles on stall_cnt_o. Without it, stall_cnt_o is tied to 0.
//
// Ports
//   clk_i, rst_i           clock, asynchronous active-high reset
//   valid_i, halt_i        upstream op valid, block acceptance of new ops
//   flush_i, stall_i       kill op in stage, downstream not ready
//   mem_read_i/_write_i    op is load / store
//   wb_sel_i, reg_write_i  writeback controls
//   rd_i, result_i         destination register, ALU result / address
//   write_data_i           store data
//   dmem_req_o/_we_o       memory request / request is write
//   dmem_addr_o/_wdata_o   request address / write data
//   dmem_ack_i/_rdata_i    completion pulse / load data valid with ack
//   valid_o, reg_write_o   output op valid, register write (gated by valid_o)
//   wb_sel_o, rd_o         forwarded controls / destination
//   result_o, read_data_o  forwarded result / load data
//   stall_o                stage busy, upstream must hold
//   stall_cnt_o            stall-cycle counter
// -----------------------------------------------------------------------------
module mem_stage_hs #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_W   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              halt_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              wb_sel_i,
  input  logic              reg_write_i,
  input  logic [RD_W-1:0]   rd_i,
  input  logic [ADDR_W-1:0] result_i,
  input  logic [DATA_W-1:0] write_data_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              valid_o,
  output logic              reg_write_o,
  output logic              wb_sel_o,
  output logic [RD_W-1:0]   rd_o,
  output logic [ADDR_W-1:0] result_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic              stall_o,
  output logic [31:0]       stall_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              r_state,     w_state;
  logic                r_busy,      w_busy;
  logic                r_valid,     w_valid;
  logic                r_reg_write, w_reg_write;
  logic                r_wb_sel,    w_wb_sel;
  logic [RD_W-1:0]     r_rd,        w_rd;
  logic [ADDR_W-1:0]   r_result,    w_result;
  logic [DATA_W-1:0]   r_read_data, w_read_data;
  logic                r_req,       w_req;
  logic                r_we,        w_we;
  logic [ADDR_W-1:0]   r_addr,      w_addr;
  logic [DATA_W-1:0]   r_wdata,     w_wdata;
  // Register-write intent of the memory op in flight; released only on a live completion.
  logic                r_pend_rw,   w_pend_rw;
  logic                r_is_load,   w_is_load;
  // Set by a flush while BUSY: the handshake still finishes but the op is dropped.
  logic                r_killed,    w_killed;
  logic                w_accept;

  // Next-state and next-output logic.
  always_comb begin
    w_state     = r_state;
    w_valid     = r_valid;
    w_reg_write = r_reg_write;
    w_wb_sel    = r_wb_sel;
    w_rd        = r_rd;
    w_result    = r_result;
    w_read_data = r_read_data;
    w_req       = r_req;
    w_we        = r_we;
    w_addr      = r_addr;
    w_wdata     = r_wdata;
    w_pend_rw   = r_pend_rw;
    w_is_load   = r_is_load;
    w_killed    = r_killed;
    w_accept    = valid_i && !halt_i && !flush_i && !stall_i && !r_busy;

    case (r_state)
      S_IDLE: begin
        if (flush_i) begin
          w_valid     = 1'b0;
          w_reg_write = 1'b0;
        end else if (stall_i) begin
          // Downstream not ready: hold the presented op unchanged.
          w_valid = r_valid;
        end else if (w_accept) begin
          w_rd     = rd_i;
          w_result = result_i;
          w_wb_sel = wb_sel_i;
          if (mem_read_i || mem_write_i) begin
            w_state     = S_BUSY;
            w_req       = 1'b1;
            w_we        = mem_write_i;
            w_addr      = result_i;
            w_wdata     = write_data_i;
            w_is_load   = mem_read_i;
            w_pend_rw   = reg_write_i;
            w_killed    = 1'b0;
            w_valid     = 1'b0;
            w_reg_write = 1'b0;
          end else begin
            w_valid     = 1'b1;
            w_reg_write = reg_write_i;
          end
        end else begin
          w_valid     = 1'b0;
          w_reg_write = 1'b0;
        end
      end

      S_BUSY: begin
        w_killed = r_killed || flush_i;
        if (dmem_ack_i) begin
          w_req = 1'b0;
          w_we  = 1'b0;
          if (r_is_load) begin
            w_read_data = dmem_rdata_i;
          end
          w_valid     = !w_killed;
          w_reg_write = !w_killed && r_pend_rw;
          w_state     = stall_i ? S_DONE : S_IDLE;
        end
      end

      S_DONE: begin
        // Result is consumed when the stall clears, or dropped on flush.
        if (flush_i || !stall_i) begin
          w_valid     = 1'b0;
          w_reg_write = 1'b0;
          w_state     = S_IDLE;
        end
      end

      default: begin
        w_state     = S_IDLE;
        w_valid     = 1'b0;
        w_reg_write = 1'b0;
        w_req       = 1'b0;
      end
    endcase

    w_busy = (w_state != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_wb_sel    <= 1'b0;
      r_rd        <= '0;
      r_result    <= '0;
      r_read_data <= '0;
      r_req       <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_pend_rw   <= 1'b0;
      r_is_load   <= 1'b0;
      r_killed    <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_busy      <= w_busy;
      r_valid     <= w_valid;
      r_reg_write <= w_reg_write;
      r_wb_sel    <= w_wb_sel;
      r_rd        <= w_rd;
      r_result    <= w_result;
      r_read_data <= w_read_data;
      r_req       <= w_req;
      r_we        <= w_we;
      r_addr      <= w_addr;
      r_wdata     <= w_wdata;
      r_pend_rw   <= w_pend_rw;
      r_is_load   <= w_is_load;
      r_killed    <= w_killed;
    end
  end

`ifdef MEM_STALL_CNT_EN
  logic [31:0] r_stall_cnt;

  // Saturating count of cycles spent with the stage busy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= 32'd0;
    end else if (r_busy && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = 32'd0;
`endif

  assign dmem_req_o   = r_req;
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign valid_o      = r_valid;
  assign reg_write_o  = r_reg_write;
  assign wb_sel_o     = r_wb_sel;
  assign rd_o         = r_rd;
  assign result_o     = r_result;
  assign read_data_o  = r_read_data;
  assign stall_o      = r_busy;

endmodule

// File: tb/tb_mem_stage_hs.sv
// -----------------------------------------------------------------------------
// tb_mem_stage_hs : directed bench for mem_stage_hs. Expected results and memory
// requests go into scoreboard queues when an op is issued. They are popped and
// compared when the stage presents them. Inputs change on negedge, and outputs
// are sampled on negedge.
// -----------------------------------------------------------------------------
module tb_mem_stage_hs;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned RD_W   = 4;
`ifdef MEM_STALL_CNT_EN
  localparam logic [31:0] EXP_CNT5 = 32'd5;
`else
  localparam logic [31:0] EXP_CNT5 = 32'd0;
`endif

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              valid_i, halt_i, flush_i, stall_i;
  logic              mem_read_i, mem_write_i, wb_sel_i, reg_write_i;
  logic [RD_W-1:0]   rd_i;
  logic [ADDR_W-1:0] result_i;
  logic [DATA_W-1:0] write_data_i;
  logic              dmem_req_o, dmem_we_o;
  logic [ADDR_W-1:0] dmem_addr_o;
  logic [DATA_W-1:0] dmem_wdata_o;
  logic              dmem_ack_i;
  logic [DATA_W-1:0] dmem_rdata_i;
  logic              valid_o, reg_write_o, wb_sel_o, stall_o;
  logic [RD_W-1:0]   rd_o;
  logic [ADDR_W-1:0] result_o;
  logic [DATA_W-1:0] read_data_o;
  logic [31:0]       stall_cnt_o;

  mem_stage_hs #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_W(RD_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .halt_i(halt_i),
    .flush_i(flush_i), .stall_i(stall_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .wb_sel_i(wb_sel_i), .reg_write_i(reg_write_i),
    .rd_i(rd_i), .result_i(result_i), .write_data_i(write_data_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .valid_o(valid_o), .reg_write_o(reg_write_o), .wb_sel_o(wb_sel_o), .rd_o(rd_o),
    .result_o(result_o), .read_data_o(read_data_o), .stall_o(stall_o),
    .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [RD_W-1:0]   rd;
    logic [ADDR_W-1:0] result;
    logic              rw;
    logic              wb;
    logic [DATA_W-1:0] rdata;
  } out_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mreq_t;

  out_t  out_q[$];
  mreq_t mem_q[$];
  mreq_t cur_req;
  int    n_checks = 0;
  int    n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  task automatic drive_idle();
    valid_i      = 1'b0;
    mem_read_i   = 1'b0;
    mem_write_i  = 1'b0;
    wb_sel_i     = 1'b0;
    reg_write_i  = 1'b0;
    rd_i         = '0;
    result_i     = '0;
    write_data_i = '0;
  endtask

  task automatic issue(input logic rd_op, input logic wr_op, input logic rw, input logic wb,
                       input logic [RD_W-1:0] rd, input logic [ADDR_W-1:0] res,
                       input logic [DATA_W-1:0] wd);
    valid_i      = 1'b1;
    mem_read_i   = rd_op;
    mem_write_i  = wr_op;
    reg_write_i  = rw;
    wb_sel_i     = wb;
    rd_i         = rd;
    result_i     = res;
    write_data_i = wd;
  endtask

  // Waits (bounded) for valid_o, then compares against the oldest expected result.
  task automatic check_out(input string tag, input int max_wait);
    out_t e;
    int   n = 0;
    while (valid_o !== 1'b1 && n < max_wait) begin
      tick();
      n++;
    end
    chk({tag, ".valid"}, 32'(valid_o), 32'd1);
    chk({tag, ".sb"}, 32'(out_q.size() != 0), 32'd1);
    if (out_q.size() != 0) begin
      e = out_q.pop_front();
      chk({tag, ".rd"},     32'(rd_o),        32'(e.rd));
      chk({tag, ".result"}, 32'(result_o),    32'(e.result));
      chk({tag, ".rw"},     32'(reg_write_o), 32'(e.rw));
      chk({tag, ".wb"},     32'(wb_sel_o),    32'(e.wb));
      chk({tag, ".rdata"},  32'(read_data_o), 32'(e.rdata));
    end
  endtask

  task automatic check_mem(input string tag);
    chk({tag, ".msb"}, 32'(mem_q.size() != 0), 32'd1);
    if (mem_q.size() != 0) cur_req = mem_q.pop_front();
    chk({tag, ".req"},   32'(dmem_req_o),   32'd1);
    chk({tag, ".we"},    32'(dmem_we_o),    32'(cur_req.we));
    chk({tag, ".addr"},  32'(dmem_addr_o),  32'(cur_req.addr));
    chk({tag, ".wdata"}, 32'(dmem_wdata_o), 32'(cur_req.wdata));
  endtask

  task automatic check_hold(input string tag);
    chk({tag, ".req"},   32'(dmem_req_o),   32'd1);
    chk({tag, ".we"},    32'(dmem_we_o),    32'(cur_req.we));
    chk({tag, ".addr"},  32'(dmem_addr_o),  32'(cur_req.addr));
    chk({tag, ".wdata"}, 32'(dmem_wdata_o), 32'(cur_req.wdata));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1; halt_i = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
    dmem_ack_i = 1'b0; dmem_rdata_i = '0; cur_req = '0;
    drive_idle();
    repeat (2) tick();
    chk("rst.valid", 32'(valid_o), 32'd0);
    chk("rst.stall", 32'(stall_o), 32'd0);
    chk("rst.req",   32'(dmem_req_o), 32'd0);
    chk("rst.rw",    32'(reg_write_o), 32'd0);
    chk("rst.res",   32'(result_o), 32'd0);
    chk("rst.cnt",   stall_cnt_o, 32'd0);
    rst_i = 1'b0;
    tick();

    // ALU op passes through in one cycle
    issue(1'b0, 1'b0, 1'b1, 1'b0, 4'd3, 16'h1234, 16'h0);
    out_q.push_back(out_t'{rd: 4'd3, result: 16'h1234, rw: 1'b1, wb: 1'b0, rdata: 16'h0});
    tick(); drive_idle();
    check_out("alu", 0);
    chk("alu.stall", 32'(stall_o), 32'd0);
    tick();
    chk("alu.pulse", 32'(valid_o), 32'd0);
    chk("alu.rwgate", 32'(reg_write_o), 32'd0);

    // Load, ack three cycles after the request rises
    issue(1'b1, 1'b0, 1'b1, 1'b1, 4'd5, 16'h0040, 16'h0);
    mem_q.push_back(mreq_t'{we: 1'b0, addr: 16'h0040, wdata: 16'h0});
    out_q.push_back(out_t'{rd: 4'd5, result: 16'h0040, rw: 1'b1, wb: 1'b1, rdata: 16'hBEEF});
    tick(); drive_idle();
    check_mem("ld");
    chk("ld.busy", 32'(stall_o), 32'd1);
    chk("ld.nv",   32'(valid_o), 32'd0);
    for (int c = 1; c < 3; c++) begin
      tick();
      check_hold($sformatf("ld.hold%0d", c));
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = 16'hBEEF;
    tick(); dmem_ack_i = 1'b0; dmem_rdata_i = 16'h0;
    check_out("ld", 0);
    chk("ld.reqdrop", 32'(dmem_req_o), 32'd0);
    chk("ld.idle",    32'(stall_o), 32'd0);

    // Store acked while downstream stalls -> DONE holds the result
    issue(1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 16'h0010, 16'hA5A5);
    mem_q.push_back(mreq_t'{we: 1'b1, addr: 16'h0010, wdata: 16'hA5A5});
    out_q.push_back(out_t'{rd: 4'd7, result: 16'h0010, rw: 1'b0, wb: 1'b0, rdata: 16'hBEEF});
    tick(); drive_idle();
    check_mem("st");
    dmem_ack_i = 1'b1; stall_i = 1'b1;
    tick(); dmem_ack_i = 1'b0;
    chk("st.done", 32'(stall_o), 32'd1);
    check_out("st", 0);
    chk("st.reqdrop", 32'(dmem_req_o), 32'd0);
    tick();
    chk("st.hvalid", 32'(valid_o), 32'd1);
    chk("st.hstall", 32'(stall_o), 32'd1);
    chk("st.hrd",    32'(rd_o), 32'd7);
    stall_i = 1'b0;
    tick();
    chk("st.idle", 32'(stall_o), 32'd0);
    chk("st.cons", 32'(valid_o), 32'd0);

    // halt blocks acceptance; an ack outside BUSY is ignored
    issue(1'b0, 1'b0, 1'b1, 1'b0, 4'd1, 16'h9999, 16'h0);
    halt_i = 1'b1; dmem_ack_i = 1'b1; dmem_rdata_i = 16'h0BAD;
    tick(); drive_idle(); halt_i = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = 16'h0;
    chk("halt.valid",  32'(valid_o), 32'd0);
    chk("halt.stall",  32'(stall_o), 32'd0);
    chk("stray.req",   32'(dmem_req_o), 32'd0);
    chk("stray.rdata", 32'(read_data_o), 32'hBEEF);

    // stall_i freezes the presented op; flush in IDLE clears it
    issue(1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 16'h00AA, 16'h0);
    out_q.push_back(out_t'{rd: 4'd4, result: 16'h00AA, rw: 1'b1, wb: 1'b1, rdata: 16'hBEEF});
    tick(); drive_idle(); stall_i = 1'b1;
    check_out("frz", 0);
    tick();
    chk("frz.valid", 32'(valid_o), 32'd1);
    chk("frz.res",   32'(result_o), 32'h00AA);
    flush_i = 1'b1;
    tick(); flush_i = 1'b0; stall_i = 1'b0;
    chk("flush.valid", 32'(valid_o), 32'd0);
    chk("flush.rw",    32'(reg_write_o), 32'd0);

    // Flush during a BUSY load: handshake completes, op is dropped
    issue(1'b1, 1'b0, 1'b1, 1'b0, 4'd9, 16'h0080, 16'h0);
    mem_q.push_back(mreq_t'{we: 1'b0, addr: 16'h0080, wdata: 16'h0});
    tick(); drive_idle();
    check_mem("kl");
    flush_i = 1'b1;
    tick(); flush_i = 1'b0;
    check_hold("kl.hold");
    chk("kl.busy", 32'(stall_o), 32'd1);
    dmem_ack_i = 1'b1; dmem_rdata_i = 16'h1111;
    tick(); dmem_ack_i = 1'b0; dmem_rdata_i = 16'h0;
    chk("kl.valid", 32'(valid_o), 32'd0);
    chk("kl.rw",    32'(reg_write_o), 32'd0);
    chk("kl.req",   32'(dmem_req_o), 32'd0);
    chk("kl.idle",  32'(stall_o), 32'd0);
    issue(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 16'h5678, 16'h0);
    out_q.push_back(out_t'{rd: 4'd2, result: 16'h5678, rw: 1'b1, wb: 1'b0, rdata: 16'h1111});
    tick(); drive_idle();
    check_out("post", 0);

    // Counter from a clean reset, then reset in the middle of BUSY
    rst_i = 1'b1;
    tick();
    chk("rst2.cnt", stall_cnt_o, 32'd0);
    rst_i = 1'b0;
    tick();
    issue(1'b1, 1'b0, 1'b1, 1'b0, 4'd1, 16'h0100, 16'h0);
    mem_q.push_back(mreq_t'{we: 1'b0, addr: 16'h0100, wdata: 16'h0});
    tick(); drive_idle();
    check_mem("rb");
    chk("rb.cnt0", stall_cnt_o, 32'd0);
    repeat (5) tick();
    chk("rb.cnt5", stall_cnt_o, EXP_CNT5);
    check_hold("rb.hold");
    #2 rst_i = 1'b1;
    #1;
    chk("rb.async_req", 32'(dmem_req_o), 32'd0);
    chk("rb.async_stall", 32'(stall_o), 32'd0);
    chk("rb.async_cnt", stall_cnt_o, 32'd0);
    tick();
    rst_i = 1'b0;
    tick();
    chk("rb.after", 32'(dmem_req_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
